full_sched: RTL and testbench

Run-time scheduler for the two-stage fully-connected network (st0 → st1 → error stage).
- Holds off sample traffic until tap loading reports load_finish.
- Meters st_data into the network one VEC_LEN-word vector at a time, generating the fst marker itself.
- Caps vectors in flight at MAX_INFLIGHT, counts completed vectors at st_data_out, and signals done after NUM vectors.

---
 rtl/full_sched_if.sv | 26 ++
 rtl/full_sched.sv | 205 ++++++++++++++++++++
 tb/tb_full_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/full_sched_if.sv
// Sample-stream bundle between source buffer, scheduler and the two-stage FC network.
// master = scheduler side, slave = source/network side.
interface full_sched_if;
  logic [31:0] src_data;
  logic        src_vld;
  logic        src_rdy;
  logic [31:0] st_data;
  logic        st_data_vld;
  logic        st_data_fst;
  logic        st_data_rdy;
  logic        st_data_out_vld;
  logic        st_data_out_fst;
  logic        st_data_out_rdy;

  modport master (
    input  src_data, src_vld, st_data_rdy,
    input  st_data_out_vld, st_data_out_fst, st_data_out_rdy,
    output src_rdy, st_data, st_data_vld, st_data_fst
  );

  modport slave (
    output src_data, src_vld, st_data_rdy,
    output st_data_out_vld, st_data_out_fst, st_data_out_rdy,
    input  src_rdy, st_data, st_data_vld, st_data_fst
  );
endinterface

// File: rtl/full_sched.sv
// Run-time scheduler: meters VEC_LEN-word vectors into the FC network, caps vectors in flight.
// Optional LOAD/DRAIN watchdog enabled by defining FULL_SCHED_TIMEOUT_EN.
module full_sched #(
  parameter int VEC_LEN      = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             load_finish,
  full_sched_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] vec_issued,
  output logic [CNT_W-1:0] vec_done
);

  localparam int WC_W = (VEC_LEN > 2) ? $clog2(VEC_LEN) : 1;
  localparam int IF_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [IF_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]  vec_issued_q, vec_issued_d;
  logic [CNT_W-1:0]  vec_done_q, vec_done_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              gate_s, accept_s, ret_s, first_s, last_s;

`ifdef FULL_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              wd_active_s, timeout_s;
`endif

  // Issue gate: only vector boundaries are throttled, a started vector always completes.
  always_comb begin
    gate_s = 1'b0;
    if (state_q == S_RUN) begin
      if (word_cnt_q != '0) begin
        gate_s = 1'b1;
      end else begin
        gate_s = (inflight_q < IF_W'(MAX_INFLIGHT)) && (vec_issued_q < num_q);
      end
    end else begin
      gate_s = 1'b0;
    end
  end

  assign bus.st_data     = bus.src_data;
  assign bus.st_data_vld = bus.src_vld & gate_s;
  assign bus.src_rdy     = bus.st_data_rdy & gate_s;
  assign bus.st_data_fst = (word_cnt_q == '0);

  assign accept_s = bus.src_vld & bus.src_rdy;
  assign first_s  = accept_s & (word_cnt_q == '0);
  assign last_s   = accept_s & (word_cnt_q == WC_W'(VEC_LEN - 1));
  assign ret_s    = bus.st_data_out_vld & bus.st_data_out_rdy & bus.st_data_out_fst &
                    ((state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN));

  // Next-state, counter and flag computation.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    word_cnt_d   = word_cnt_q;
    inflight_d   = inflight_q;
    vec_issued_d = vec_issued_q;
    vec_done_d   = vec_done_q;
    err_d        = err_q;
    done_d       = 1'b0;

    if (accept_s) begin
      word_cnt_d = last_s ? '0 : word_cnt_q + WC_W'(1);
    end else begin
      word_cnt_d = word_cnt_q;
    end
    if (last_s) begin
      vec_issued_d = vec_issued_q + CNT_W'(1);
    end else begin
      vec_issued_d = vec_issued_q;
    end
    if (ret_s) begin
      vec_done_d = vec_done_q + CNT_W'(1);
    end else begin
      vec_done_d = vec_done_q;
    end

    // A return with nothing in flight is a protocol error; the count stays clamped at zero.
    case ({first_s, ret_s})
      2'b10:   inflight_d = inflight_q + IF_W'(1);
      2'b01: begin
        if (inflight_q == '0) begin
          err_d      = 1'b1;
          inflight_d = '0;
        end else begin
          inflight_d = inflight_q - IF_W'(1);
        end
      end
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d        = num_vec;
          err_d        = 1'b0;
          word_cnt_d   = '0;
          inflight_d   = '0;
          vec_issued_d = '0;
          vec_done_d   = '0;
          state_d      = (num_vec == '0) ? S_DONE : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:  state_d = load_finish ? S_RUN : S_LOAD;
      S_RUN:   state_d = (vec_issued_d == num_q) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = (vec_done_q >= num_q) ? S_DONE : S_DRAIN;
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FULL_SCHED_TIMEOUT_EN
    wd_active_s = (state_q == S_LOAD) || (state_q == S_DRAIN);
    timeout_s   = wd_active_s && !ret_s && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    if (timeout_s) begin
      err_d   = 1'b1;
      state_d = S_DONE;
    end else begin
      err_d = err_d;
    end
    if ((state_d != state_q) || ret_s || !wd_active_s) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      word_cnt_d   = '0;
      inflight_d   = '0;
      vec_issued_d = vec_issued_q;
      vec_done_d   = vec_done_q;
      done_d       = 1'b0;
    end else begin
      done_d = done_d;
    end
  end

  // State and counter registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      word_cnt_q   <= '0;
      inflight_q   <= '0;
      vec_issued_q <= '0;
      vec_done_q   <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
`ifdef FULL_SCHED_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      word_cnt_q   <= word_cnt_d;
      inflight_q   <= inflight_d;
      vec_issued_q <= vec_issued_d;
      vec_done_q   <= vec_done_d;
      err_q        <= err_d;
      done_q       <= done_d;
`ifdef FULL_SCHED_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign vec_issued = vec_issued_q;
  assign vec_done   = vec_done_q;

endmodule

// File: tb/tb_full_sched.sv
// Directed self-checking bench for full_sched with a delayed-loopback network model.
module tb_full_sched;
  localparam int VEC_LEN      = 16;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 16;
  localparam int TIMEOUT_CYC  = 4096;
  localparam int LOOP_DLY     = 20;
  localparam logic [31:0] DATA_BASE = 32'hA000_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             load_finish = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             busy, done, err;
  logic [2:0]       state;
  logic [CNT_W-1:0] vec_issued, vec_done;

  logic loop_en = 1'b0;
  logic man_ret = 1'b0;
  logic out_rdy = 1'b1;
  logic rand_rdy = 1'b0;

  int acc_cnt = 0, fst_cnt = 0, data_err = 0, fst_err = 0, gate_viol = 0, done_cnt = 0;
  int pos_base = 0;
  logic [LOOP_DLY-1:0] ret_pipe = '0;
  int n_chk = 0, n_fail = 0;

  full_sched_if bus_if();

  full_sched #(
    .VEC_LEN(VEC_LEN), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_vec(num_vec),
    .load_finish(load_finish), .bus(bus_if), .busy(busy), .done(done), .err(err),
    .state(state), .vec_issued(vec_issued), .vec_done(vec_done)
  );

  always #5 clk = ~clk;

  assign bus_if.src_data        = DATA_BASE + 32'(acc_cnt);
  assign bus_if.st_data_out_vld = man_ret | (loop_en & ret_pipe[LOOP_DLY-1]);
  assign bus_if.st_data_out_fst = man_ret | (loop_en & ret_pipe[LOOP_DLY-1]);
  assign bus_if.st_data_out_rdy = out_rdy;

  // Scoreboard of accepted words plus the network loopback delay line.
  always @(posedge clk) begin
    if (bus_if.src_vld && bus_if.src_rdy) begin
      acc_cnt <= acc_cnt + 1;
      if (bus_if.st_data !== DATA_BASE + 32'(acc_cnt)) data_err <= data_err + 1;
      if (bus_if.st_data_fst !== (((acc_cnt - pos_base) % VEC_LEN) == 0)) fst_err <= fst_err + 1;
      if (bus_if.st_data_fst) fst_cnt <= fst_cnt + 1;
    end
    if (bus_if.st_data_vld && (state != 3'd2)) gate_viol <= gate_viol + 1;
    if (done) done_cnt <= done_cnt + 1;
    ret_pipe <= {ret_pipe[LOOP_DLY-2:0],
                 bus_if.src_vld & bus_if.src_rdy & bus_if.st_data_fst};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rand_rdy) bus_if.st_data_rdy = 1'($urandom_range(0, 1));
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    num_vec  = n;
    pos_base = acc_cnt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (acc_cnt - pos_base == n) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int d0, f0;
    bus_if.src_vld     = 1'b1;
    bus_if.st_data_rdy = 1'b1;

    // Reset
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_src_rdy", 32'(bus_if.src_rdy), 32'd0);
    check("rst_vld", 32'(bus_if.st_data_vld), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_issued", 32'(vec_issued), 32'd0);
    reset = 1'b1;
    tick();

    // Basic run: 2 vectors, loopback network
    loop_en = 1'b1;
    d0 = done_cnt; f0 = fst_cnt;
    pulse_start(16'd2);
    check("t1_load_state", 32'(state), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    repeat (10) tick();
    check("t1_no_load_traffic", 32'(acc_cnt - pos_base), 32'd0);
    load_finish = 1'b1;
    wait_done("t1_done_seen", 300);
    tick();
    check("t1_words", 32'(acc_cnt - pos_base), 32'd32);
    check("t1_fst_cnt", 32'(fst_cnt - f0), 32'd2);
    check("t1_issued", 32'(vec_issued), 32'd2);
    check("t1_vdone", 32'(vec_done), 32'd2);
    check("t1_err", 32'(err), 32'd0);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_idle", 32'(state), 32'd0);

    // Inflight cap: 6 vectors, no returns for 100 cycles
    loop_en = 1'b0;
    d0 = done_cnt;
    pulse_start(16'd6);
    repeat (99) tick();
    check("t2_words_capped", 32'(acc_cnt - pos_base), 32'd64);
    check("t2_issued_capped", 32'(vec_issued), 32'd4);
    check("t2_gate_closed", 32'(bus_if.src_rdy), 32'd0);
    check("t2_state_run", 32'(state), 32'd2);
    man_ret = 1'b1; tick(); man_ret = 1'b0;
    check("t2_gate_reopen", 32'(bus_if.src_rdy), 32'd1);
    check("t2_fst_5th", 32'(bus_if.st_data_fst), 32'd1);
    tick();
    repeat (2) begin man_ret = 1'b1; tick(); man_ret = 1'b0; end
    repeat (40) tick();
    check("t2_issued_all", 32'(vec_issued), 32'd6);
    check("t2_state_drain", 32'(state), 32'd3);
    repeat (3) begin man_ret = 1'b1; tick(); man_ret = 1'b0; tick(); end
    wait_done("t2_done_seen", 20);
    tick();
    check("t2_vdone", 32'(vec_done), 32'd6);
    check("t2_words", 32'(acc_cnt - pos_base), 32'd96);
    check("t2_err", 32'(err), 32'd0);
    check("t2_done_once", 32'(done_cnt - d0), 32'd1);

    // Random backpressure, loopback on
    loop_en = 1'b1;
    rand_rdy = 1'b1;
    pulse_start(16'd3);
    wait_done("t3_done_seen", 800);
    rand_rdy = 1'b0;
    bus_if.st_data_rdy = 1'b1;
    loop_en = 1'b0;
    check("t3_words", 32'(acc_cnt - pos_base), 32'd48);
    check("t3_vdone", 32'(vec_done), 32'd3);
    check("t3_err", 32'(err), 32'd0);
    check("t3_data_order", 32'(data_err), 32'd0);
    check("t3_fst_pos", 32'(fst_err), 32'd0);

    // Same-cycle issue and return with 2 in flight
    pulse_start(16'd7);
    for (int i = 0; i < 60; i++) begin
      if (acc_cnt - pos_base == 32) break;
      tick();
    end
    bus_if.st_data_rdy = 1'b0;
    check("t4_two_issued", 32'(vec_issued), 32'd2);
    tick();
    bus_if.st_data_rdy = 1'b1;
    man_ret = 1'b1;
    tick();
    man_ret = 1'b0;
    check("t4_first_word_taken", 32'(acc_cnt - pos_base), 32'd33);
    check("t4_vdone", 32'(vec_done), 32'd1);
    repeat (80) tick();
    check("t4_issued_stall", 32'(vec_issued), 32'd5);
    check("t4_gate_closed", 32'(bus_if.src_rdy), 32'd0);
    d0 = done_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_abort_idle", 32'(state), 32'd0);

    // Spurious return in LOAD, then abort at word 7
    load_finish = 1'b0;
    pulse_start(16'd3);
    check("t5_load_state", 32'(state), 32'd1);
    check("t5_err_cleared", 32'(err), 32'd0);
    man_ret = 1'b1; tick(); man_ret = 1'b0;
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_vdone", 32'(vec_done), 32'd1);
    load_finish = 1'b1;
    wait_words("t5_reach_w7", 7, 40);
    abort = 1'b1;
    bus_if.st_data_rdy = 1'b0;
    tick();
    abort = 1'b0;
    bus_if.st_data_rdy = 1'b1;
    check("t5_abort_idle", 32'(state), 32'd0);
    check("t5_src_rdy", 32'(bus_if.src_rdy), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_err_sticky", 32'(err), 32'd1);
    check("t5_words", 32'(acc_cnt - pos_base), 32'd7);

    // num_vec==0 skips LOAD
    pulse_start(16'd0);
    check("t6_state_done", 32'(state), 32'd4);
    check("t6_err_cleared", 32'(err), 32'd0);
    check("t6_done_early", 32'(done), 32'd0);
    tick();
    check("t6_done_pulse", 32'(done), 32'd1);
    check("t6_idle", 32'(state), 32'd0);
    tick();
    check("t6_done_single", 32'(done), 32'd0);

`ifdef FULL_SCHED_TIMEOUT_EN
    load_finish = 1'b0;
    pulse_start(16'd1);
    wait_done("t7_timeout_done", TIMEOUT_CYC + 20);
    check("t7_timeout_err", 32'(err), 32'd1);
    load_finish = 1'b1;
`endif

    check("gen_gate_viol", 32'(gate_viol), 32'd0);
    check("gen_data_err", 32'(data_err), 32'd0);
    check("gen_fst_err", 32'(fst_err), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
